// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC selection with exception, flush, halt and stall-count sequencing
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_current,
  input  logic        branch_taken,
  input  logic [31:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        exception,
  input  logic [4:0]  exc_code,
  output logic [31:0] pc_next,
  output logic        flush,
  output logic        halted,
  output logic [31:0] epc,
  output logic [4:0]  cause,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);
  localparam logic [4:0] CAUSE_ADEL = 5'd4;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        halt_pend_q, halt_pend_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  cause_q, cause_d;
  logic [15:0] stall_q, stall_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] flow_pc;
  logic [31:0] sel_pc;
  logic        jr_misaligned;
  logic        take_exc;
  logic [15:0] stall_inc;

  assign pc_plus4      = pc_current + 32'd4;
  assign br_target     = pc_plus4 + (branch_imm << 2);
  assign j_target      = {pc_plus4[31:28], jump_index, 2'b00};
  assign jr_misaligned = jr && (jr_addr[1:0] != 2'b00);
  assign stall_inc     = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;

  // Ordinary control-flow choice shared by RUN and FLUSH (halt, stall, jr, jump, branch, fall-through).
  always_comb begin
    flow_pc = pc_plus4;
    if (halt_req)          flow_pc = pc_plus4;
    else if (stall)        flow_pc = pc_current;
    else if (jr)           flow_pc = jr_addr;
    else if (jump)         flow_pc = j_target;
    else if (branch_taken) flow_pc = br_target;
  end

  // Next-state and next-PC selection; exceptions pre-empt everything in RUN and HALT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    halt_pend_d = halt_pend_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    stall_d     = stall_q;
    sel_pc      = pc_plus4;
    take_exc    = 1'b0;

    unique case (state_q)
      S_RUN:   take_exc = exception || jr_misaligned;
      S_HALT:  take_exc = exception;
      default: take_exc = 1'b0;
    endcase

    if (take_exc) begin
      sel_pc      = EXC_VECTOR;
      epc_d       = pc_current;
      cause_d     = exception ? exc_code : CAUSE_ADEL;
      state_d     = S_FLUSH;
      cnt_d       = FLUSH_INIT;
      halt_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          sel_pc = flow_pc;
          if (halt_req)   state_d = S_HALT;
          else if (stall) stall_d = stall_inc;
        end
        S_FLUSH: begin
          sel_pc = flow_pc;
          // A halt seen during flush is remembered and honoured once the flush window closes.
          if (halt_req)   halt_pend_d = 1'b1;
          else if (stall) stall_d = stall_inc;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            cnt_d       = 4'd0;
            state_d     = (halt_pend_q || halt_req) ? S_HALT : S_RUN;
            halt_pend_d = 1'b0;
          end
        end
        S_HALT: begin
          sel_pc = pc_current;
          if (resume) state_d = S_RUN;
        end
        default: begin
          sel_pc  = pc_plus4;
          state_d = S_RUN;
        end
      endcase
    end
  end

  // Sequencer state, exception record and stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RUN;
      cnt_q       <= 4'd0;
      halt_pend_q <= 1'b0;
      epc_q       <= 32'd0;
      cause_q     <= 5'd0;
      stall_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      halt_pend_q <= halt_pend_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
      stall_q     <= stall_d;
    end
  end

  assign pc_next      = reset ? sel_pc : RESET_VECTOR;
  assign flush        = (state_q == S_FLUSH);
  assign halted       = (state_q == S_HALT);
  assign epc          = epc_q;
  assign cause        = cause_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a behavioural model
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] EV = 32'h0000_0180;
  localparam int          FC = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_current;
  logic        branch_taken;
  logic [31:0] branch_imm;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_addr;
  logic        stall;
  logic        halt_req;
  logic        resume;
  logic        exception;
  logic [4:0]  exc_code;
  logic [31:0] pc_next;
  logic        flush;
  logic        halted;
  logic [31:0] epc;
  logic [4:0]  cause;
  logic [15:0] stall_cycles;

  pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EV), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .pc_current(pc_current),
    .branch_taken(branch_taken), .branch_imm(branch_imm),
    .jump(jump), .jump_index(jump_index), .jr(jr), .jr_addr(jr_addr),
    .stall(stall), .halt_req(halt_req), .resume(resume),
    .exception(exception), .exc_code(exc_code),
    .pc_next(pc_next), .flush(flush), .halted(halted),
    .epc(epc), .cause(cause), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model
  bit          m_halted;
  int          m_flush_left;
  bit          m_pend;
  logic [31:0] m_epc;
  logic [4:0]  m_cause;
  longint      m_stalls;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_flush_left = 0; m_pend = 0;
    m_epc = 32'd0; m_cause = 5'd0; m_stalls = 0;
  endtask

  function automatic logic [31:0] exp_pc();
    logic [31:0] p4;
    p4 = pc_current + 32'd4;
    if (!reset) return RV;
    if (m_halted) return exception ? EV : pc_current;
    if (m_flush_left == 0 && (exception || (jr && jr_addr[1:0] != 2'b00))) return EV;
    if (halt_req) return p4;
    if (stall) return pc_current;
    if (jr) return jr_addr;
    if (jump) return {p4[31:28], jump_index, 2'b00};
    if (branch_taken) return p4 + (branch_imm << 2);
    return p4;
  endfunction

  function automatic logic [15:0] exp_stalls();
    return (m_stalls > 65535) ? 16'hFFFF : 16'(m_stalls);
  endfunction

  task automatic take(input logic [4:0] c);
    m_epc = pc_current; m_cause = c; m_flush_left = FC; m_pend = 0; m_halted = 0;
  endtask

  task automatic model_update();
    if (m_halted) begin
      if (exception) take(exc_code);
      else if (resume) m_halted = 0;
    end else if (m_flush_left > 0) begin
      if (halt_req) m_pend = 1;
      else if (stall) m_stalls++;
      m_flush_left--;
      if (m_flush_left == 0) begin
        m_halted = m_pend;
        m_pend = 0;
      end
    end else begin
      if (exception) take(exc_code);
      else if (jr && jr_addr[1:0] != 2'b00) take(5'd4);
      else if (halt_req) m_halted = 1;
      else if (stall) m_stalls++;
    end
  endtask

  task automatic compare_all();
    check("pc_next", pc_next, exp_pc());
    check("flush", {31'd0, flush}, {31'd0, (m_flush_left > 0)});
    check("halted", {31'd0, halted}, {31'd0, m_halted});
    check("epc", epc, m_epc);
    check("cause", {27'd0, cause}, {27'd0, m_cause});
    check("stall_cycles", {16'd0, stall_cycles}, {16'd0, exp_stalls()});
  endtask

  // inputs already applied just after a rising edge
  task automatic cycle();
    #1;
    compare_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branch_taken = 0; branch_imm = 0; jump = 0; jump_index = 0;
    jr = 0; jr_addr = 0; stall = 0; halt_req = 0; resume = 0;
    exception = 0; exc_code = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    #1;
    check("rst_pc_next", pc_next, RV);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_epc", epc, 32'd0);
    check("rst_stall", {16'd0, stall_cycles}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic randomize_inputs();
    pc_current   = $urandom();
    branch_taken = ($urandom_range(0, 2) == 0);
    branch_imm   = $urandom();
    jump         = ($urandom_range(0, 4) == 0);
    jump_index   = 26'($urandom());
    jr           = ($urandom_range(0, 5) == 0);
    jr_addr      = $urandom();
    if ($urandom_range(0, 2) != 0) jr_addr[1:0] = 2'b00;
    stall        = ($urandom_range(0, 4) == 0);
    halt_req     = ($urandom_range(0, 24) == 0);
    resume       = ($urandom_range(0, 3) == 0);
    exception    = ($urandom_range(0, 19) == 0);
    exc_code     = 5'($urandom());
  endtask

  initial begin
    idle();
    pc_current = 32'h40;
    reset = 0;
    #3;
    check("init_pc_next", pc_next, RV);
    check("init_flush", {31'd0, flush}, 32'd0);
    check("init_halted", {31'd0, halted}, 32'd0);
    check("init_epc", epc, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1;

    // fall-through after release
    #1 check("release_p4", pc_next, 32'h44);
    cycle();

    // branch backwards, then jump with region bits
    pc_current = 32'h100; branch_taken = 1; branch_imm = 32'hFFFF_FFFC;
    #1 check("branch", pc_next, 32'hF4);
    cycle();
    idle(); jump = 1; jump_index = 26'h10; pc_current = 32'h8000_0000;
    #1 check("jump", pc_next, 32'h8000_0040);
    cycle();

    // exception, then one ignored during flush
    idle(); pc_current = 32'h200; exception = 1; exc_code = 5'd12;
    #1 check("exc_vec", pc_next, EV);
    cycle();
    exception = 1; exc_code = 5'd7; pc_current = 32'h204;
    #1 check("exc_flush", {31'd0, flush}, 32'd1);
    check("exc_epc", epc, 32'h200);
    check("exc_cause", {27'd0, cause}, 32'd12);
    check("exc_masked_pc", pc_next, 32'h208);
    cycle();
    idle(); pc_current = 32'h208;
    #1 check("flush_done", {31'd0, flush}, 32'd0);
    check("epc_kept", epc, 32'h200);
    cycle();

    // misaligned jr, then jr beats jump
    pc_current = 32'h300; jr = 1; jr_addr = 32'h1002;
    #1 check("jr_mis_pc", pc_next, EV);
    cycle();
    idle(); pc_current = 32'h180;
    #1 check("jr_mis_epc", epc, 32'h300);
    check("jr_mis_cause", {27'd0, cause}, 32'd4);
    cycle();
    jr = 1; jump = 1; jr_addr = 32'h2000; jump_index = 26'h3;
    #1 check("jr_over_jump", pc_next, 32'h2000);
    cycle();

    // three stall cycles
    idle(); stall = 1; pc_current = 32'h50;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_hold", pc_next, 32'h50);
      cycle();
    end
    idle();
    #1 check("stall_cnt3", {16'd0, stall_cycles}, 32'd3);
    cycle();

    // halt, track, resume
    halt_req = 1; pc_current = 32'h60;
    #1 check("halt_pc", pc_next, 32'h64);
    cycle();
    idle(); pc_current = 32'h64; stall = 1;
    #1 check("halted_1", {31'd0, halted}, 32'd1);
    check("halt_track", pc_next, 32'h64);
    cycle();
    stall = 0; resume = 1; halt_req = 1;
    #1 check("resume_pc", pc_next, 32'h64);
    cycle();
    idle();
    #1 check("resumed", {31'd0, halted}, 32'd0);
    cycle();

    // asynchronous reset while halted
    halt_req = 1; pc_current = 32'h70;
    cycle();
    idle();
    #1 check("halted_2", {31'd0, halted}, 32'd1);
    reset = 0;
    #1 check("async_halted", {31'd0, halted}, 32'd0);
    check("async_pc", pc_next, RV);
    model_reset();
    @(posedge clk);
    #1 reset = 1;

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        idle();
        do_reset();
      end
      randomize_inputs();
      cycle();
    end

    // stall counter saturation from a clean start
    idle();
    do_reset();
    stall = 1; pc_current = 32'h50;
    for (int i = 0; i < 65540; i++) begin
      model_update();
      @(posedge clk);
    end
    #1;
    check("stall_sat", {16'd0, stall_cycles}, 32'h0000_FFFF);
    cycle();
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-address controller for the single-cycle MIPS fetch path.
- Takes the current PC from Program_Counter plus decoded control-flow requests. Drives PC_in with the selected next address.
- Owns the exception (EPC/cause), halt and flush sequencing around the PC register.
- Also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
RESET_VECTOR, 32'h0000_0000, value driven on pc_next while reset is asserted.
EXC_VECTOR, 32'h0000_0180, exception handler entry address.
FLUSH_CYCLES, 1, cycles flush stays high after an exception is taken (range 1-15).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset.
pc_current  input  32  current PC value (Program_Counter PC_out).
branch_taken  input  1  conditional branch resolved taken.
branch_imm  input  32  sign-extended 16-bit branch offset, in words.
jump  input  1  J/JAL request.
jump_index  input  26  instr[25:0].
jr  input  1  JR/JALR request.
jr_addr  input  32  register-sourced target.
stall  input  1  hold PC this cycle.
halt_req  input  1  halt instruction executing.
resume  input  1  leave HALT.
exception  input  1  synchronous exception from datapath.
exc_code  input  5  cause code accompanying exception.
pc_next  output  32  next PC (Program_Counter PC_in), combinational.
flush  output  1  suppress register-file and memory writes of the current instruction.
halted  output  1  high in HALT state.
epc  output  32  PC of the faulting instruction.
cause  output  5  latched cause code.
stall_cycles  output  16  saturating count of stalled cycles.

Behaviour:
- Reset (reset low, asynchronous):
  - Registered state: state=RUN, epc=0, cause=0, flush counter=0, stall_cycles=0.
  - Outputs: pc_next=RESET_VECTOR, flush=0, halted=0.
- Reset release: first rising edge with reset high uses normal selection.
- Arithmetic: all address arithmetic is 32-bit modulo 2^32, with wrap allowed and no flags.
  - pc_plus4 = pc_current+4.
  - br_target = pc_plus4 + (branch_imm<<2).
  - j_target = {pc_plus4[31:28], jump_index, 2'b00}.
- States:
  - RUN: normal fetch.
  - FLUSH: FLUSH_CYCLES cycles after an exception.
  - HALT: PC frozen.
- RUN selection, priority high to low (decided combinationally; registered effects at the next edge):
  1. exception: pc_next=EXC_VECTOR; epc<=pc_current; cause<=exc_code; go to FLUSH with counter=FLUSH_CYCLES.
  2. jr with jr_addr[1:0]!=0: treated as an exception with cause 5'd4 (AdEL), same actions as 1.
  3. halt_req: pc_next=pc_plus4; go to HALT.
  4. stall: pc_next=pc_current; stall_cycles+1, saturating at 16'hFFFF.
  5. jr: pc_next=jr_addr.
  6. jump: pc_next=j_target.
  7. branch_taken: pc_next=br_target.
  8. Otherwise: pc_next=pc_plus4.
- FLUSH:
  - flush=1 (registered, asserted from the edge that enters FLUSH).
  - pc_next follows RUN priorities 3-8. Exceptions and the misaligned-jr check are masked.
  - Counter decrements each cycle; at 1 → RUN next edge with flush=0.
  - halt_req in FLUSH still moves to HALT after the counter expires. Its pc_next takes effect immediately; the state change is deferred.
- HALT:
  - pc_next=pc_current; halted=1.
  - stall is ignored and stall_cycles is not incremented.
  - resume → RUN at the next edge; pc_next stays pc_current in the resume cycle.
  - exception in HALT is taken exactly as in RUN (priority over resume).
- Simultaneous events:
  - exception with stall: exception wins and no stall count.
  - jr with jump: jr wins.
  - resume with halt_req in HALT: resume wins, halt_req ignored.
- Reset asserted mid-FLUSH or mid-HALT: immediate return to reset values; the flush counter is cleared.

Test Plan:
- Reset low, pc_current=32'h40 → pc_next=0, flush=0, halted=0, epc=0. Release, no requests → pc_next=32'h44.
- pc_current=32'h100, branch_taken, branch_imm=32'hFFFF_FFFC → pc_next=32'hF4. Then jump, jump_index=26'h10, pc_current=32'h8000_0000 → pc_next=32'h8000_0040.
- pc_current=32'h200, exception, exc_code=5'd12 → pc_next=32'h180. Next cycle: epc=32'h200, cause=12, flush=1 for 1 cycle. A second exception during flush → ignored, epc unchanged.
- jr with jr_addr=32'h1002 at pc_current=32'h300 → pc_next=32'h180, epc=32'h300, cause=4. jr with jump both high, jr_addr=32'h2000 → pc_next=32'h2000.
- stall high for 3 cycles at pc_current=32'h50 → pc_next=32'h50 each cycle, stall_cycles=3. Preload via 65 540 stall cycles → stall_cycles holds 16'hFFFF.
- halt_req at pc_current=32'h60 → pc_next=32'h64, halted=1 next cycle, pc_next tracks pc_current. resume → halted=0 next cycle. Reset pulse while halted → halted=0 immediately, without waiting for a clock edge.
